// File: rtl/sram_periph_resp_pkg.sv
//------------------------------------------------------------------------------
// Module   : sram_periph_resp_pkg
// Brief    : Shared register offsets, defaults and helper functions for the
//            data-SRAM peripheral responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sram_periph_resp_pkg;

  // Register offsets within the decoded 16-bit address window
  localparam logic [15:0] c_off_cr0         = 16'h8000;
  localparam logic [15:0] c_off_cr1         = 16'h8004;
  localparam logic [15:0] c_off_cr2         = 16'h8008;
  localparam logic [15:0] c_off_cr3         = 16'h800c;
  localparam logic [15:0] c_off_timer       = 16'he000;
  localparam logic [15:0] c_off_led         = 16'hf000;
  localparam logic [15:0] c_off_led_rg0     = 16'hf004;
  localparam logic [15:0] c_off_led_rg1     = 16'hf008;
  localparam logic [15:0] c_off_num         = 16'hf010;
  localparam logic [15:0] c_off_switch      = 16'hf020;
  localparam logic [15:0] c_off_btn         = 16'hf024;
  localparam logic [15:0] c_off_io_simu     = 16'hffec;
  localparam logic [15:0] c_off_simu_flag   = 16'hfff4;
  localparam logic [15:0] c_off_open_trace  = 16'hfff8;
  localparam logic [15:0] c_off_num_monitor = 16'hfffc;

  localparam logic [31:0] c_simu_flag_default = 32'hffff_ffff;

  // Replace each byte lane of old_v with new_v where the lane enable is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Hex digit to segments {a,b,c,d,e,f,g}, a in the MSB, active-high
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'ha: s = 7'b1110111;
      4'hb: s = 7'b0011111;
      4'hc: s = 7'b1001110;
      4'hd: s = 7'b0111101;
      4'he: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_periph_resp_if.sv
//------------------------------------------------------------------------------
// Module   : sram_periph_resp_if
// Brief    : CPU data-SRAM port bundle (request + registered read data).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sram_periph_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_periph_resp_seg7_scan.sv
//------------------------------------------------------------------------------
// Module   : seg7_scan
// Brief    : Multiplexed 8-digit seven-segment driver. Each digit is held for
//            SCAN_DIV cycles, then the scan advances to the next nibble.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_scan
  import sram_periph_resp_pkg::*;
#(
  parameter logic [19:0] SCAN_DIV = 20'd100000
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  input  wire logic [31:0] num,
  output logic      [7:0]  num_csn,
  output logic      [6:0]  num_a_g
);

  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;

  // Dwell counter; on its wrap the digit index steps (and wraps 7->0 naturally)
  always_comb begin
    cnt_d = cnt_q + 20'd1;
    idx_d = idx_q;
    if (cnt_q == SCAN_DIV - 20'd1) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Scan state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign num_csn = ~(8'd1 << idx_q);
  assign num_a_g = seg7_decode(num[{idx_q, 2'b00} +: 4]);

endmodule

`default_nettype wire

// File: rtl/sram_periph_resp.sv
//------------------------------------------------------------------------------
// Module   : sram_periph_resp
// Brief    : Peripheral responder on the CPU data-SRAM port. Register file,
//            input synchronizers and a one-cycle-latency read mux; drives the
//            seven-segment scanner from the NUM register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sram_periph_resp
  import sram_periph_resp_pkg::*;
#(
  parameter logic [31:0] SIMU_FLAG = c_simu_flag_default,
  parameter logic [19:0] SCAN_DIV  = 20'd100000
) (
  input  wire logic              clk,
  input  wire logic              resetn,
  sram_periph_resp_if.slave      bus,
  input  wire logic [7:0]        switch,
  input  wire logic [3:0]        btn,
  output logic      [15:0]       led,
  output logic      [1:0]        led_rg0,
  output logic      [1:0]        led_rg1,
  output logic      [7:0]        num_csn,
  output logic      [6:0]        num_a_g
);

  logic [15:0] w_off;
  logic        w_wr;
  logic        w_unused_addr;

  logic [31:0] cr0_q, cr0_d, cr1_q, cr1_d, cr2_q, cr2_d, cr3_q, cr3_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [1:0]  rg0_q, rg0_d, rg1_q, rg1_d;
  logic [31:0] num_q, num_d;
  logic [31:0] io_simu_q, io_simu_d;
  logic        open_trace_q, open_trace_d;
  logic        num_monitor_q, num_monitor_d;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic [3:0]  btn_meta_q, btn_sync_q;
  logic [31:0] rdata_q, rdata_d;

  assign w_off         = bus.data_sram_addr[15:0];
  assign w_wr          = bus.data_sram_en && (bus.data_sram_wen != 4'h0);
  assign w_unused_addr = ^bus.data_sram_addr[31:16];

  // Register-file next state: byte-lane writes, free-running timer
  always_comb begin
    cr0_d         = cr0_q;
    cr1_d         = cr1_q;
    cr2_d         = cr2_q;
    cr3_d         = cr3_q;
    timer_d       = timer_q + 32'd1;
    led_d         = led_q;
    rg0_d         = rg0_q;
    rg1_d         = rg1_q;
    num_d         = num_q;
    io_simu_d     = io_simu_q;
    open_trace_d  = open_trace_q;
    num_monitor_d = num_monitor_q;
    if (w_wr) begin
      case (w_off)
        c_off_cr0:   cr0_d   = byte_merge(cr0_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_cr1:   cr1_d   = byte_merge(cr1_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_cr2:   cr2_d   = byte_merge(cr2_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_cr3:   cr3_d   = byte_merge(cr3_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_timer: timer_d = byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_num:   num_d   = byte_merge(num_q, bus.data_sram_wdata, bus.data_sram_wen);
        c_off_led: begin
          if (bus.data_sram_wen[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
          if (bus.data_sram_wen[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
        end
        c_off_led_rg0: if (bus.data_sram_wen[0]) rg0_d = bus.data_sram_wdata[1:0];
        c_off_led_rg1: if (bus.data_sram_wen[0]) rg1_d = bus.data_sram_wdata[1:0];
        // Half-word swapped full-word store regardless of which lanes are enabled
        c_off_io_simu: io_simu_d = {bus.data_sram_wdata[15:0], bus.data_sram_wdata[31:16]};
        c_off_open_trace:  if (bus.data_sram_wen[0]) open_trace_d  = bus.data_sram_wdata[0];
        c_off_num_monitor: if (bus.data_sram_wen[0]) num_monitor_d = bus.data_sram_wdata[0];
        default: ;
      endcase
    end
  end

  // Read mux samples pre-edge register values; rdata holds when idle
  always_comb begin
    rdata_d = rdata_q;
    if (bus.data_sram_en) begin
      case (w_off)
        c_off_cr0:         rdata_d = cr0_q;
        c_off_cr1:         rdata_d = cr1_q;
        c_off_cr2:         rdata_d = cr2_q;
        c_off_cr3:         rdata_d = cr3_q;
        c_off_timer:       rdata_d = timer_q;
        c_off_led:         rdata_d = {16'h0, led_q};
        c_off_led_rg0:     rdata_d = {30'h0, rg0_q};
        c_off_led_rg1:     rdata_d = {30'h0, rg1_q};
        c_off_num:         rdata_d = num_q;
        c_off_switch:      rdata_d = {24'h0, sw_sync_q};
        c_off_btn:         rdata_d = {28'h0, btn_sync_q};
        c_off_io_simu:     rdata_d = io_simu_q;
        c_off_simu_flag:   rdata_d = SIMU_FLAG;
        c_off_open_trace:  rdata_d = {31'h0, open_trace_q};
        c_off_num_monitor: rdata_d = {31'h0, num_monitor_q};
        default:           rdata_d = 32'h0;
      endcase
    end
  end

  // All architectural state plus the two-flop switch/button synchronizers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cr0_q         <= '0;
      cr1_q         <= '0;
      cr2_q         <= '0;
      cr3_q         <= '0;
      timer_q       <= '0;
      led_q         <= 16'hffff;
      rg0_q         <= '0;
      rg1_q         <= '0;
      num_q         <= '0;
      io_simu_q     <= '0;
      open_trace_q  <= 1'b1;
      num_monitor_q <= 1'b1;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      btn_meta_q    <= '0;
      btn_sync_q    <= '0;
      rdata_q       <= '0;
    end else begin
      cr0_q         <= cr0_d;
      cr1_q         <= cr1_d;
      cr2_q         <= cr2_d;
      cr3_q         <= cr3_d;
      timer_q       <= timer_d;
      led_q         <= led_d;
      rg0_q         <= rg0_d;
      rg1_q         <= rg1_d;
      num_q         <= num_d;
      io_simu_q     <= io_simu_d;
      open_trace_q  <= open_trace_d;
      num_monitor_q <= num_monitor_d;
      sw_meta_q     <= switch;
      sw_sync_q     <= sw_meta_q;
      btn_meta_q    <= btn;
      btn_sync_q    <= btn_meta_q;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;
  assign led_rg0             = rg0_q;
  assign led_rg1             = rg1_q;

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg7_scan (
    .clk     (clk),
    .resetn  (resetn),
    .num     (num_q),
    .num_csn (num_csn),
    .num_a_g (num_a_g)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_periph_resp.sv
//------------------------------------------------------------------------------
// Module   : tb_sram_periph_resp
// Brief    : Directed, table-driven bench for sram_periph_resp.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_periph_resp;
  import sram_periph_resp_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  switch = 8'h00;
  logic [3:0]  btn = 4'h0;
  logic [15:0] led;
  logic [1:0]  led_rg0, led_rg1;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;

  int checks = 0;
  int errors = 0;

  sram_periph_resp_if bus();

  sram_periph_resp #(
    .SIMU_FLAG (32'hffff_ffff),
    .SCAN_DIV  (20'd4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .switch  (switch),
    .btn     (btn),
    .led     (led),
    .led_rg0 (led_rg0),
    .led_rg1 (led_rg1),
    .num_csn (num_csn),
    .num_a_g (num_a_g)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive one request at the falling edge, let it be taken, sample 1 after
  task automatic xfer(input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'h0000_f000, 32'h0,          32'h0000_ffff};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_fff8, 32'h0,          32'h0000_0001};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_fffc, 32'h0,          32'h0000_0001};
    vecs[3]  = '{1'b1, 4'hf, 32'h0000_8000, 32'h1122_3344,  32'h0000_0000};
    vecs[4]  = '{1'b1, 4'h2, 32'h0000_8000, 32'haabb_ccdd,  32'h1122_3344};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_8000, 32'h0,          32'h1122_cc44};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_1234, 32'h0,          32'h1122_cc44};
    vecs[7]  = '{1'b1, 4'h1, 32'h0000_ffec, 32'h1234_5678,  32'h0000_0000};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_ffec, 32'h0,          32'h5678_1234};
    vecs[9]  = '{1'b1, 4'hf, 32'h0000_fff4, 32'h0,          32'hffff_ffff};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_fff4, 32'h0,          32'hffff_ffff};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_1234, 32'h0,          32'h0000_0000};
    vecs[12] = '{1'b1, 4'hf, 32'h0000_f000, 32'h1234_5678,  32'h0000_ffff};
    vecs[13] = '{1'b1, 4'h0, 32'h0000_f000, 32'h0,          32'h0000_5678};
    vecs[14] = '{1'b1, 4'h1, 32'h0000_f004, 32'h0000_00ff,  32'h0000_0000};
    vecs[15] = '{1'b1, 4'h0, 32'h0000_f004, 32'h0,          32'h0000_0003};
    vecs[16] = '{1'b1, 4'h2, 32'h0000_f008, 32'h0000_0202,  32'h0000_0000};
    vecs[17] = '{1'b1, 4'h0, 32'h0000_f008, 32'h0,          32'h0000_0000};
    vecs[18] = '{1'b1, 4'h9, 32'h0000_800c, 32'hdead_beef,  32'h0000_0000};
    vecs[19] = '{1'b1, 4'h0, 32'h0000_800c, 32'h0,          32'hde00_00ef};
    vecs[20] = '{1'b1, 4'hf, 32'h0000_fff8, 32'h0,          32'h0000_0001};
    vecs[21] = '{1'b1, 4'h0, 32'h0000_fff8, 32'h0,          32'h0000_0000};
    vecs[22] = '{1'b1, 4'hf, 32'h0001_8004, 32'hcafe_f00d,  32'h0000_0000};
    vecs[23] = '{1'b1, 4'h0, 32'h0000_8004, 32'h0,          32'hcafe_f00d};
    vecs[24] = '{1'b1, 4'h0, 32'h0000_8008, 32'h0,          32'h0000_0000};

    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", bus.data_sram_rdata, 32'h0);
    chk("reset_led", {16'h0, led}, 32'h0000_ffff);
    chk("reset_csn", {24'h0, num_csn}, 32'h0000_00fe);
    @(negedge clk);
    resetn = 1'b1;

    // Table-driven register accesses
    for (int i = 0; i < 25; i++) begin
      xfer(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d", i), bus.data_sram_rdata, vecs[i].exp);
    end
    chk("led_port", {16'h0, led}, 32'h0000_5678);
    chk("led_rg0_port", {30'h0, led_rg0}, 32'h0000_0003);
    chk("led_rg1_port", {30'h0, led_rg1}, 32'h0000_0000);

    // TIMER: write 0x100 at edge N, read issued at edge N+5
    xfer(1'b1, 4'hf, 32'h0000_e000, 32'h0000_0100);
    repeat (4) xfer(1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b1, 4'h0, 32'h0000_e000, 32'h0);
    chk("timer_plus4", bus.data_sram_rdata, 32'h0000_0104);
    // TIMER wrap
    xfer(1'b1, 4'hf, 32'h0000_e000, 32'hffff_ffff);
    xfer(1'b0, 4'h0, 32'h0, 32'h0);
    xfer(1'b1, 4'h0, 32'h0000_e000, 32'h0);
    chk("timer_wrap", bus.data_sram_rdata, 32'h0000_0000);

    // Synchronizer latency: change before edge K
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    switch = 8'h5a;
    btn    = 4'h9;
    @(posedge clk);
    xfer(1'b1, 4'h0, 32'h0000_f020, 32'h0);
    chk("switch_k1_old", bus.data_sram_rdata, 32'h0000_0000);
    xfer(1'b1, 4'h0, 32'h0000_f020, 32'h0);
    chk("switch_k2_new", bus.data_sram_rdata, 32'h0000_005a);
    xfer(1'b1, 4'h0, 32'h0000_f024, 32'h0);
    chk("btn_sync", bus.data_sram_rdata, 32'h0000_0009);

    // Mid-stream asynchronous reset
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("midrst_rdata", bus.data_sram_rdata, 32'h0);
    chk("midrst_led", {16'h0, led}, 32'h0000_ffff);
    chk("midrst_rg0", {30'h0, led_rg0}, 32'h0);
    chk("midrst_csn", {24'h0, num_csn}, 32'h0000_00fe);
    repeat (2) @(posedge clk);

    // Release and write NUM=3 in the first edge after release (k=1)
    @(negedge clk);
    resetn = 1'b1;
    bus.data_sram_en    = 1'b1;
    bus.data_sram_wen   = 4'hf;
    bus.data_sram_addr  = 32'h0000_f010;
    bus.data_sram_wdata = 32'h0000_0003;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 36; k++) begin
      automatic int idx = (k / 4) % 8;
      automatic logic [7:0] ecsn = ~(8'd1 << idx);
      automatic logic [6:0] eag = (idx == 0) ? 7'b1111001 : 7'b1111110;
      chk($sformatf("scan_csn_k%0d", k), {24'h0, num_csn}, {24'h0, ecsn});
      chk($sformatf("scan_ag_k%0d", k), {25'h0, num_a_g}, {25'h0, eag});
      if (k == 1) begin
        @(negedge clk);
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'h0;
      end
      @(posedge clk);
      #1;
    end

    // First requests after reset behave as from cold
    xfer(1'b1, 4'h0, 32'h0000_f000, 32'h0);
    chk("cold_led", bus.data_sram_rdata, 32'h0000_ffff);
    xfer(1'b1, 4'h0, 32'h0000_8000, 32'h0);
    chk("cold_cr0", bus.data_sram_rdata, 32'h0000_0000);
    xfer(1'b1, 4'h0, 32'h0000_f010, 32'h0);
    chk("num_readback", bus.data_sram_rdata, 32'h0000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
